// File: rtl/ustawienie_zakresu.sv
// Multi-cycle bit-range unit: SET/CLEAR/TOGGLE/COUNT over the inclusive index range [B..C] of A,
// one bit per clock, under a start/busy/done handshake.
module ustawienie_zakresu #(
    parameter int unsigned BITS = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic [1:0]             i_mode,
    input  logic signed [BITS-1:0] i_arg_A,
    input  logic signed [BITS-1:0] i_arg_B,
    input  logic signed [BITS-1:0] i_arg_C,
    output logic signed [BITS-1:0] o_result,
    output logic                   o_error,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam int unsigned IdxW = $clog2(BITS);
    localparam logic signed [BITS-1:0] MaxIdx = $signed(BITS'(BITS - 1));

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;
    typedef enum logic [1:0] {ModeSet, ModeClear, ModeToggle, ModeCount} mode_e;

    state_e            state_q, state_d;
    mode_e             mode_q, mode_d;
    logic [BITS-1:0]   a_q, a_d;
    logic [BITS-1:0]   count_q, count_d;
    logic [BITS-1:0]   result_q, result_d;
    logic              error_q, error_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [IdxW-1:0]   last_q, last_d;

    logic              args_bad;
    logic              bit_new;
    logic [BITS-1:0]   a_new;
    logic [BITS-1:0]   count_new;

    // Both indices are signed, so a negative value fails the sign test before any compare matters.
    assign args_bad = i_arg_B[BITS-1] | i_arg_C[BITS-1] | (i_arg_B > MaxIdx) |
                      (i_arg_C > MaxIdx) | (i_arg_B > i_arg_C);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (i_start) state_d = args_bad ? StDone : StRun;
            StRun:   if (idx_q == last_q) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        o_busy   = (state_q == StRun);
        o_done   = (state_q == StDone);
        o_result = result_q;
        o_error  = error_q;
    end

    // Bit operation at the current index
    always_comb begin
        unique case (mode_q)
            ModeSet:    bit_new = 1'b1;
            ModeClear:  bit_new = 1'b0;
            ModeToggle: bit_new = ~a_q[idx_q];
            default:    bit_new = a_q[idx_q];
        endcase
        a_new          = a_q;
        a_new[idx_q]   = bit_new;
        count_new      = count_q + BITS'(a_q[idx_q]);
    end

    always_comb begin
        a_d      = a_q;
        mode_d   = mode_q;
        count_d  = count_q;
        result_d = result_q;
        error_d  = error_q;
        idx_d    = idx_q;
        last_d   = last_q;
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    if (args_bad) begin
                        error_d  = 1'b1;
                        result_d = '0;
                    end else begin
                        error_d = 1'b0;
                        a_d     = i_arg_A;
                        mode_d  = mode_e'(i_mode);
                        idx_d   = i_arg_B[IdxW-1:0];
                        last_d  = i_arg_C[IdxW-1:0];
                        count_d = '0;
                    end
                end
            end
            StRun: begin
                a_d     = a_new;
                count_d = count_new;
                // Result is loaded on the final edge so it is already valid during the done pulse.
                if (idx_q == last_q) begin
                    result_d = (mode_q == ModeCount) ? count_new : a_new;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            a_q      <= '0;
            mode_q   <= ModeSet;
            count_q  <= '0;
            result_q <= '0;
            error_q  <= 1'b0;
            idx_q    <= '0;
            last_q   <= '0;
        end else begin
            a_q      <= a_d;
            mode_q   <= mode_d;
            count_q  <= count_d;
            result_q <= result_d;
            error_q  <= error_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
        end
    end

endmodule

// File: tb/tb_ustawienie_zakresu.sv
// Scoreboard bench for ustawienie_zakresu: stimulus pushes expected completions, a monitor
// compares them (plus o_busy every cycle) when the DUT pulses o_done.
module tb_ustawienie_zakresu;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_start;
    logic [1:0]  i_mode;
    logic [31:0] i_arg_A, i_arg_B, i_arg_C;
    logic [31:0] o_result;
    logic        o_error, o_busy, o_done;

    typedef struct {
        logic [31:0] result;
        logic        err;
        int          k;      // edge count when start was driven; accepted at edge k+1
        int          n;      // bits processed (0 for argument errors)
        bit          abort;  // request killed by reset: no completion expected
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    logic rst_seen = 1'b0;
    bit   stim_done = 1'b0;
    int   applied = 0;
    int   miscompares = 0;

    ustawienie_zakresu #(.BITS(32)) dut (
        .i_clk    (clk),
        .i_rst    (i_rst),
        .i_start  (i_start),
        .i_mode   (i_mode),
        .i_arg_A  (i_arg_A),
        .i_arg_B  (i_arg_B),
        .i_arg_C  (i_arg_C),
        .o_result (o_result),
        .o_error  (o_error),
        .o_busy   (o_busy),
        .o_done   (o_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= i_rst;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c);
        i_mode  = m;
        i_arg_A = a;
        i_arg_B = b;
        i_arg_C = c;
        i_start = 1'b1;
    endtask

    task automatic issue(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] r, input logic e, input int n);
        drive(m, a, b, c);
        q.push_back('{result: r, err: e, k: cyc, n: n, abort: 1'b0});
        @(negedge clk);
        i_start = 1'b0;
        repeat (n + 1) @(negedge clk);
    endtask

    // Monitor / scoreboard
    initial begin
        exp_t e;
        logic busy_exp;
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                if (q.size() > 0 && q[0].abort && cyc >= q[0].k + q[0].n + 1) void'(q.pop_front());
                busy_exp = (q.size() > 0 && cyc > q[0].k && cyc <= q[0].k + q[0].n);
                chk("busy", {31'b0, o_busy}, {31'b0, busy_exp});
                if (rst_seen) begin
                    chk("reset_result", o_result, 32'd0);
                    chk("reset_error", {31'b0, o_error}, 32'd0);
                end
                if (o_done) begin
                    if (q.size() == 0) begin
                        chk("unexpected_done", {31'b0, o_done}, 32'd0);
                    end else begin
                        e = q.pop_front();
                        chk("result", o_result, e.result);
                        chk("error", {31'b0, o_error}, {31'b0, e.err});
                        chk("done_cycle", 32'(cyc), 32'(e.k + e.n + 1));
                    end
                end else if (q.size() > 0 && !q[0].abort && cyc >= q[0].k + q[0].n + 1) begin
                    chk("missing_done", {31'b0, o_done}, 32'd1);
                    void'(q.pop_front());
                end
            end
            if (stim_done) begin
                chk("pending_at_end", 32'(q.size()), 32'd0);
                $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
                $finish;
            end
        end
    end

    // Stimulus
    initial begin
        i_rst   = 1'b1;
        i_start = 1'b0;
        i_mode  = 2'b00;
        i_arg_A = '0;
        i_arg_B = '0;
        i_arg_C = '0;
        repeat (3) @(negedge clk);
        i_rst = 1'b0;
        @(negedge clk);

        issue(2'b00, 32'h0000_0000, 32'd4, 32'd7,  32'h0000_00F0, 1'b0, 4);
        issue(2'b01, 32'hFFFF_FFFF, 32'd0, 32'd31, 32'h0000_0000, 1'b0, 32);
        issue(2'b10, 32'h0000_FF00, 32'd4, 32'd11, 32'h0000_F0F0, 1'b0, 8);
        issue(2'b11, 32'hF0F0_F0F0, 32'd0, 32'd31, 32'd16,        1'b0, 32);
        issue(2'b11, 32'h0000_0001, 32'd0, 32'd0,  32'd1,         1'b0, 1);
        // Argument errors: negative B, B > C, C out of range, negative C
        issue(2'b00, 32'h1234_5678, 32'hFFFF_FFFF, 32'd3, 32'd0, 1'b1, 0);
        issue(2'b00, 32'h1234_5678, 32'd8, 32'd3,          32'd0, 1'b1, 0);
        issue(2'b00, 32'h1234_5678, 32'd0, 32'd32,         32'd0, 1'b1, 0);
        issue(2'b01, 32'h1234_5678, 32'd0, 32'hFFFF_FFFB,  32'd0, 1'b1, 0);
        issue(2'b00, 32'h0000_0000, 32'd0, 32'd0, 32'h0000_0001, 1'b0, 1);

        // Second start during RUN must be ignored
        drive(2'b00, 32'h0000_0000, 32'd8, 32'd11);
        q.push_back('{result: 32'h0000_0F00, err: 1'b0, k: cyc, n: 4, abort: 1'b0});
        @(negedge clk);
        drive(2'b01, 32'hFFFF_FFFF, 32'd0, 32'd0);
        @(negedge clk);
        i_start = 1'b0;
        repeat (4) @(negedge clk);

        // Reset two edges into a 10-bit operation
        drive(2'b00, 32'h0000_0000, 32'd0, 32'd9);
        q.push_back('{result: 32'd0, err: 1'b0, k: cyc, n: 1, abort: 1'b1});
        @(negedge clk);
        i_start = 1'b0;
        i_rst   = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        repeat (12) @(negedge clk);

        issue(2'b11, 32'hFFFF_FFFF, 32'd28, 32'd31, 32'd4, 1'b0, 4);

        repeat (3) @(negedge clk);
        stim_done = 1'b1;
    end

endmodule
